gemm_operand_feeder: RTL and testbench
======================================

# gemm_operand_feeder

Producer side of the low-bit GEMM operand stream. It reads X rows and W tiles from operand buffers, decomposes multi-bit elements into 2-bit slice codes, and drives the `act_*`/`wgt_*` beats that the GEMM core consumes. The beat order (m, n-tile, k-tile, slice pair) matches the core's accumulate/advance order exactly. It sits between the operand SRAMs and the GEMM core, one feeder per core.

## Interface
- `IC2_LANES`, 16: K elements per beat.
- `OC2_LANES`, 16: W rows (N lanes) per beat.
- `EL_W`, 16: stored element width in bits; must be ≥ 16.
- `ADDR_W`, 16: buffer address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `cfg_m`, `cfg_k`, `cfg_n`  in  16 each  matrix dims; sampled on accepted `start`.
- `cfg_act_bits`, `cfg_wgt_bits`  in  8 each  element bits, legal values 2/4/8/16; sampled on `start`.
- `start`  in  1  launch; accepted only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.
- `cfg_err`  out  1  one-cycle pulse, coincident with `done`, when the config is illegal.
- `x_rd_en`  out  1  X buffer read strobe.
- `x_rd_addr`  out  ADDR_W  X read address = m·k_tiles + kt.
- `x_rd_data`  in  IC2_LANES×EL_W  X elements; valid exactly 1 cycle after `x_rd_en`.
- `w_rd_en`  out  1  W buffer read strobe.
- `w_rd_addr`  out  ADDR_W  W read address = nt·k_tiles + kt.
- `w_rd_data`  in  OC2_LANES×IC2_LANES×EL_W  W elements; valid exactly 1 cycle after `w_rd_en`.
- `act_in[IC2_LANES]`  out  3 each  {zero_flag, code}.
- `act_valid`, `wgt_valid`  out  1 each  beat valid; always driven identically.
- `act_ready`, `wgt_ready`  in  1 each  core ready.
- `act_k_offset`  out  16  equals kt·IC2_LANES.
- `wgt_in[OC2_LANES][IC2_LANES]`  out  2 each  weight codes.
- `act_slice_sel`, `wgt_slice_sel`  out  3 each  slice index of the current beat.

## Operation
- Derived values:
  - k_tiles = ceil(cfg_k/IC2_LANES)
  - n_tiles = ceil(cfg_n/OC2_LANES)
  - as = act_bits/2, ws = wgt_bits/2
- Config error: if any dimension is 0 or either bit width is outside {2,4,8,16}:
  - the next cycle pulses `done` and `cfg_err`;
  - no reads are issued and no beats are sent.
- Loop nest, outermost first: m in [0,cfg_m), nt in [0,n_tiles), kt in [0,k_tiles), a in [0,as), w in [0,ws).
  - The w index is innermost.
  - The last beat of each k-tile has a=as-1 and w=ws-1.
- FSM states:
  - IDLE: on `start`, go to FETCH, or to ERR if the config is illegal.
  - FETCH: assert both read strobes with their addresses for 1 cycle, then go to LATCH.
  - LATCH: register `x_rd_data` and `w_rd_data` into operand holding regs, set a=w=0, then go to SEND.
  - SEND: valid is high. On a handshake (valid & act_ready & wgt_ready):
    - if w < ws-1, increment w;
    - else if a < as-1, set w=0 and increment a;
    - else advance kt/nt/m and go to FETCH, or to IDLE with a `done` pulse after the final beat.
  - ERR: 1 cycle, then IDLE.
- Slicing (both operands): code = element bits [2s+1:2s] for slice s.
- Activation zero flag: `act_in[i][2]`=1 and code=00 when kt·IC2_LANES+i ≥ cfg_k.
- Weight padding: `wgt_in[j][i]`=00 when nt·OC2_LANES+j ≥ cfg_n or the k index ≥ cfg_k.
- Element bits above act_bits/wgt_bits are ignored.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `cfg_err`, `x_rd_en`, `w_rd_en`, `act_valid`, `wgt_valid` = 0;
  - all data, address, offset and slice outputs = 0.
- Start to first valid beat is 3 cycles: `start` accepted at cycle 0, FETCH at cycle 1, LATCH at cycle 2, `act_valid` high at cycle 3.
- Each k-tile costs 2 bubble cycles (FETCH and LATCH) plus as·ws beats at full ready.
- Valid/data stability:
  - once valid is high, `act_in`, `wgt_in`, both slice selects and `act_k_offset` stay unchanged until the handshake;
  - valid never drops without a handshake.
- Outputs are registered; the ready inputs are never combinationally routed to any output.
- `start` while busy is ignored.
- `done` is asserted the cycle after the final handshake, while the state is IDLE.
- Reset asserted mid-run: returns to IDLE immediately; no `done` pulse.

## Test plan
- Basic: M=1, K=16, N=16, act_bits=2, wgt_bits=2 → exactly 1 beat, x_rd_addr=0, w_rd_addr=0, slice selects 0/0, `done` on the cycle after the beat.
- Slice order: act_bits=4, wgt_bits=8, K=16, N=16 → 8 beats with (a,w) = (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3); codes match element bits [2s+1:2s].
- K padding: K=20 → 2 k-tiles with act_k_offset 0 then 16; second tile lanes 4..15 have zero_flag=1 and code 00.
- N padding and tile order: M=2, N=20, K=16 → X reads at addresses 0,0,1,1; W reads at addresses 0,1,0,1; lanes 4..15 of nt=1 carry 00.
- Backpressure: random ready deasserted for 0–5 cycles → beat contents stable under stall, no beat lost or duplicated, beat count = M·n_tiles·k_tiles·as·ws.
- Errors and reset: act_bits=6 → `done` and `cfg_err` pulse 1 cycle after `start`, no reads issued; `rst` raised mid-SEND → all outputs return to reset values and no `done` pulse.

Source files
------------

// File: rtl/gemm_operand_feeder_if.sv
// Operand-stream bundle between the GEMM operand feeder, its
// operand buffers and the GEMM core.
interface gemm_operand_feeder_if #(
  parameter int IC2_LANES = 16,
  parameter int OC2_LANES = 16,
  parameter int EL_W      = 16,
  parameter int ADDR_W    = 16
);
  logic [15:0] cfg_m;
  logic [15:0] cfg_k;
  logic [15:0] cfg_n;
  logic [7:0]  cfg_act_bits;
  logic [7:0]  cfg_wgt_bits;
  logic        start;
  logic        busy;
  logic        done;
  logic        cfg_err;

  logic                             x_rd_en;
  logic [ADDR_W-1:0]                x_rd_addr;
  logic [IC2_LANES*EL_W-1:0]        x_rd_data;
  logic                             w_rd_en;
  logic [ADDR_W-1:0]                w_rd_addr;
  logic [OC2_LANES*IC2_LANES*EL_W-1:0] w_rd_data;

  logic [2:0]  act_in [IC2_LANES];
  logic [1:0]  wgt_in [OC2_LANES][IC2_LANES];
  logic        act_valid;
  logic        wgt_valid;
  logic        act_ready;
  logic        wgt_ready;
  logic [15:0] act_k_offset;
  logic [2:0]  act_slice_sel;
  logic [2:0]  wgt_slice_sel;

  modport master (
    input  cfg_m, cfg_k, cfg_n, cfg_act_bits, cfg_wgt_bits, start,
    input  x_rd_data, w_rd_data, act_ready, wgt_ready,
    output busy, done, cfg_err,
    output x_rd_en, x_rd_addr, w_rd_en, w_rd_addr,
    output act_in, wgt_in, act_valid, wgt_valid,
    output act_k_offset, act_slice_sel, wgt_slice_sel
  );

  modport slave (
    output cfg_m, cfg_k, cfg_n, cfg_act_bits, cfg_wgt_bits, start,
    output x_rd_data, w_rd_data, act_ready, wgt_ready,
    input  busy, done, cfg_err,
    input  x_rd_en, x_rd_addr, w_rd_en, w_rd_addr,
    input  act_in, wgt_in, act_valid, wgt_valid,
    input  act_k_offset, act_slice_sel, wgt_slice_sel
  );
endinterface

// File: rtl/gemm_operand_feeder.sv
// Streams X/W operand tiles to the GEMM core as 2-bit slice beats,
// ordered m, n-tile, k-tile, act slice, wgt slice.
module gemm_operand_feeder #(
  parameter int IC2_LANES = 16,
  parameter int OC2_LANES = 16,
  parameter int EL_W      = 16,
  parameter int ADDR_W    = 16
) (
  input  logic clk,
  input  logic rst,
  gemm_operand_feeder_if.master bus
);
  localparam int XW = IC2_LANES * EL_W;
  localparam int WW = OC2_LANES * XW;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, SEND, ERR
  } state_t;

  state_t state;

  logic [15:0] m_cfg, k_cfg, n_cfg;
  logic [15:0] k_tiles, n_tiles;
  logic [2:0]  as_max, ws_max;
  logic [15:0] m, nt, kt;
  logic [15:0] k_off, n_off;
  logic [ADDR_W-1:0] x_base, w_base;
  logic [2:0]  a, w, na, nw;
  logic [XW-1:0] x_hold, x_src;
  logic [WW-1:0] w_hold, w_src;

  logic [IC2_LANES-1:0] k_pad;
  logic [OC2_LANES-1:0] n_pad;
  logic [2:0] act_nx [IC2_LANES];
  logic [1:0] wgt_nx [OC2_LANES][IC2_LANES];

  logic legal, fire, load;
  logic last_w, last_a, last_k, last_n, last_m;

  function automatic logic bits_ok(input logic [7:0] b);
    return (b == 8'd2) || (b == 8'd4) ||
           (b == 8'd8) || (b == 8'd16);
  endfunction

  function automatic logic [1:0] slice(
    input logic [EL_W-1:0] el,
    input logic [2:0]      s
  );
    return el[{s, 1'b0} +: 2];
  endfunction

  assign legal = (bus.cfg_m != '0) && (bus.cfg_k != '0) &&
                 (bus.cfg_n != '0) &&
                 bits_ok(bus.cfg_act_bits) &&
                 bits_ok(bus.cfg_wgt_bits);

  assign last_w = (w == ws_max);
  assign last_a = (a == as_max);
  assign last_k = (kt == k_tiles - 16'd1);
  assign last_n = (nt == n_tiles - 16'd1);
  assign last_m = (m == m_cfg - 16'd1);

  // The handshake only steers state; outputs stay registered.
  assign fire = (state == SEND) && bus.act_ready && bus.wgt_ready;
  assign load = (state == LATCH) || (fire && !(last_a && last_w));

  always_comb begin
    for (int i = 0; i < IC2_LANES; i++) begin
      k_pad[i] = (32'(k_off) + 32'(i)) >= 32'(k_cfg);
    end
    for (int j = 0; j < OC2_LANES; j++) begin
      n_pad[j] = (32'(n_off) + 32'(j)) >= 32'(n_cfg);
    end
  end

  always_comb begin
    na    = '0;
    nw    = '0;
    x_src = x_hold;
    w_src = w_hold;
    if (state == LATCH) begin
      x_src = bus.x_rd_data;
      w_src = bus.w_rd_data;
    end else if (last_w) begin
      na = a + 3'd1;
    end else begin
      na = a;
      nw = w + 3'd1;
    end
    for (int i = 0; i < IC2_LANES; i++) begin
      act_nx[i] = k_pad[i] ? 3'b100 :
                  {1'b0, slice(x_src[i*EL_W +: EL_W], na)};
      for (int j = 0; j < OC2_LANES; j++) begin
        wgt_nx[j][i] = (k_pad[i] || n_pad[j]) ? 2'b00 :
          slice(w_src[(j*IC2_LANES+i)*EL_W +: EL_W], nw);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_cfg   <= '0;
      k_cfg   <= '0;
      n_cfg   <= '0;
      k_tiles <= '0;
      n_tiles <= '0;
      as_max  <= '0;
      ws_max  <= '0;
      m       <= '0;
      nt      <= '0;
      kt      <= '0;
      k_off   <= '0;
      n_off   <= '0;
      x_base  <= '0;
      w_base  <= '0;
      a       <= '0;
      w       <= '0;
      x_hold  <= '0;
      w_hold  <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.cfg_err       <= 1'b0;
      bus.x_rd_en       <= 1'b0;
      bus.w_rd_en       <= 1'b0;
      bus.x_rd_addr     <= '0;
      bus.w_rd_addr     <= '0;
      bus.act_valid     <= 1'b0;
      bus.wgt_valid     <= 1'b0;
      bus.act_k_offset  <= '0;
      bus.act_slice_sel <= '0;
      bus.wgt_slice_sel <= '0;
      for (int i = 0; i < IC2_LANES; i++) begin
        bus.act_in[i] <= '0;
        for (int j = 0; j < OC2_LANES; j++) begin
          bus.wgt_in[j][i] <= '0;
        end
      end
    end else begin
      bus.done    <= 1'b0;
      bus.cfg_err <= 1'b0;
      bus.x_rd_en <= 1'b0;
      bus.w_rd_en <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          m_cfg   <= bus.cfg_m;
          k_cfg   <= bus.cfg_k;
          n_cfg   <= bus.cfg_n;
          k_tiles <= 16'((32'(bus.cfg_k) + IC2_LANES - 1) / IC2_LANES);
          n_tiles <= 16'((32'(bus.cfg_n) + OC2_LANES - 1) / OC2_LANES);
          as_max  <= 3'((bus.cfg_act_bits >> 1) - 8'd1);
          ws_max  <= 3'((bus.cfg_wgt_bits >> 1) - 8'd1);
          m       <= '0;
          nt      <= '0;
          kt      <= '0;
          k_off   <= '0;
          n_off   <= '0;
          x_base  <= '0;
          w_base  <= '0;
          bus.busy <= 1'b1;
          if (legal) begin
            state         <= FETCH;
            bus.x_rd_en   <= 1'b1;
            bus.w_rd_en   <= 1'b1;
            bus.x_rd_addr <= '0;
            bus.w_rd_addr <= '0;
          end else begin
            state       <= ERR;
            bus.done    <= 1'b1;
            bus.cfg_err <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          x_hold           <= bus.x_rd_data;
          w_hold           <= bus.w_rd_data;
          bus.act_k_offset <= k_off;
          bus.act_valid    <= 1'b1;
          bus.wgt_valid    <= 1'b1;
          state            <= SEND;
        end
        SEND: if (fire && last_a && last_w) begin
          bus.act_valid <= 1'b0;
          bus.wgt_valid <= 1'b0;
          if (!last_k) begin
            kt            <= kt + 16'd1;
            k_off         <= k_off + 16'(IC2_LANES);
            state         <= FETCH;
            bus.x_rd_en   <= 1'b1;
            bus.w_rd_en   <= 1'b1;
            bus.x_rd_addr <= x_base + ADDR_W'(kt) + ADDR_W'(1);
            bus.w_rd_addr <= w_base + ADDR_W'(kt) + ADDR_W'(1);
          end else if (!last_n) begin
            kt            <= '0;
            k_off         <= '0;
            nt            <= nt + 16'd1;
            n_off         <= n_off + 16'(OC2_LANES);
            w_base        <= w_base + ADDR_W'(k_tiles);
            state         <= FETCH;
            bus.x_rd_en   <= 1'b1;
            bus.w_rd_en   <= 1'b1;
            bus.x_rd_addr <= x_base;
            bus.w_rd_addr <= w_base + ADDR_W'(k_tiles);
          end else if (!last_m) begin
            kt            <= '0;
            k_off         <= '0;
            nt            <= '0;
            n_off         <= '0;
            w_base        <= '0;
            m             <= m + 16'd1;
            x_base        <= x_base + ADDR_W'(k_tiles);
            state         <= FETCH;
            bus.x_rd_en   <= 1'b1;
            bus.w_rd_en   <= 1'b1;
            bus.x_rd_addr <= x_base + ADDR_W'(k_tiles);
            bus.w_rd_addr <= '0;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        ERR: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        a                 <= na;
        w                 <= nw;
        bus.act_slice_sel <= na;
        bus.wgt_slice_sel <= nw;
        for (int i = 0; i < IC2_LANES; i++) begin
          bus.act_in[i] <= act_nx[i];
          for (int j = 0; j < OC2_LANES; j++) begin
            bus.wgt_in[j][i] <= wgt_nx[j][i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_gemm_operand_feeder.sv
// Randomized bench for gemm_operand_feeder against a loop-nest
// reference model of the expected beat stream.
module tb_gemm_operand_feeder;
  localparam int IC = 16;
  localparam int OC = 16;
  localparam int EW = 16;
  localparam int AW = 16;
  localparam int LIMIT = 8000;

  typedef struct packed {
    logic [IC*3-1:0]    act;
    logic [OC*IC*2-1:0] wgt;
    logic [15:0]        koff;
    logic [2:0]         as;
    logic [2:0]         ws;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gemm_operand_feeder_if #(
    .IC2_LANES(IC), .OC2_LANES(OC), .EL_W(EW), .ADDR_W(AW)
  ) bus ();

  gemm_operand_feeder #(
    .IC2_LANES(IC), .OC2_LANES(OC), .EL_W(EW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [IC*EW-1:0]    x_mem [64];
  logic [OC*IC*EW-1:0] w_mem [64];

  always @(posedge clk) begin
    if (bus.x_rd_en) bus.x_rd_data <= x_mem[bus.x_rd_addr[5:0]];
    if (bus.w_rd_en) bus.w_rd_data <= w_mem[bus.w_rd_addr[5:0]];
  end

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int exp_x[$], exp_w[$], obs_x[$], obs_w[$];
  int first_valid, last_hs, done_it, done_cnt, err_cnt;
  int stab_err, vmis;
  bit timed_out;
  logic busy1, busy_done;

  function automatic beat_t get_beat();
    beat_t b;
    for (int i = 0; i < IC; i++) begin
      b.act[i*3 +: 3] = bus.act_in[i];
      for (int j = 0; j < OC; j++)
        b.wgt[(j*IC+i)*2 +: 2] = bus.wgt_in[j][i];
    end
    b.koff = bus.act_k_offset;
    b.as = bus.act_slice_sel;
    b.ws = bus.wgt_slice_sel;
    return b;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < 64; a++) begin
      for (int c = 0; c < IC*EW/32; c++) x_mem[a][c*32 +: 32] = $urandom;
      for (int c = 0; c < OC*IC*EW/32; c++) w_mem[a][c*32 +: 32] = $urandom;
    end
  endtask

  // Reference: walk the loop nest directly over matrix coordinates.
  function automatic void build_model(int M, int K, int N, int ab, int wb);
    int ktn, ntn, k, n;
    logic [15:0] el;
    beat_t b;
    ktn = (K + IC - 1) / IC;
    ntn = (N + OC - 1) / OC;
    exp_q.delete(); exp_x.delete(); exp_w.delete();
    for (int mi = 0; mi < M; mi++)
      for (int nti = 0; nti < ntn; nti++)
        for (int kti = 0; kti < ktn; kti++) begin
          exp_x.push_back(mi*ktn + kti);
          exp_w.push_back(nti*ktn + kti);
          for (int a = 0; a < ab/2; a++)
            for (int w = 0; w < wb/2; w++) begin
              b = '0;
              b.koff = 16'(kti*IC);
              b.as = 3'(a);
              b.ws = 3'(w);
              for (int i = 0; i < IC; i++) begin
                k = kti*IC + i;
                el = x_mem[mi*ktn + kti][i*EW +: EW];
                b.act[i*3 +: 3] = (k >= K) ? 3'b100 :
                                  {1'b0, 2'((el >> (2*a)) & 16'h3)};
                for (int j = 0; j < OC; j++) begin
                  n = nti*OC + j;
                  el = w_mem[nti*ktn + kti][(j*IC+i)*EW +: EW];
                  b.wgt[(j*IC+i)*2 +: 2] = (k >= K || n >= N) ? 2'b00 :
                                           2'((el >> (2*w)) & 16'h3);
                end
              end
              exp_q.push_back(b);
            end
        end
  endfunction

  task automatic run_job(input int M, input int K, input int N,
                         input int ab, input int wb,
                         input bit stall, input int poke);
    beat_t cur, pend_b;
    bit pend, ar, wr;
    int it, after, stall_left;
    obs_q.delete(); obs_x.delete(); obs_w.delete();
    first_valid = -1; last_hs = -1; done_it = -1;
    done_cnt = 0; err_cnt = 0; stab_err = 0; vmis = 0;
    busy1 = 1'b0; busy_done = 1'bx;
    pend = 0; pend_b = '0; after = -1; stall_left = 0; it = 0;
    @(negedge clk);
    bus.cfg_m = 16'(M); bus.cfg_k = 16'(K); bus.cfg_n = 16'(N);
    bus.cfg_act_bits = 8'(ab); bus.cfg_wgt_bits = 8'(wb);
    bus.start = 1'b1;
    bus.act_ready = 1'b1; bus.wgt_ready = 1'b1;
    while (it < LIMIT && after != 0) begin
      @(negedge clk);
      it++;
      bus.start = (it == poke);
      if (it == poke) begin
        bus.cfg_act_bits = 8'd6;
        bus.cfg_m = 16'd9;
      end
      cur = get_beat();
      if (bus.x_rd_en) obs_x.push_back(int'(bus.x_rd_addr));
      if (bus.w_rd_en) obs_w.push_back(int'(bus.w_rd_addr));
      if (bus.act_valid !== bus.wgt_valid) vmis++;
      if (pend && (bus.act_valid !== 1'b1 || cur !== pend_b)) stab_err++;
      if (it == 1) busy1 = bus.busy;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_it < 0) begin
          done_it = it;
          busy_done = bus.busy;
          after = 4;
        end
      end
      if (bus.cfg_err === 1'b1) err_cnt++;
      if (after > 0) after--;
      ar = 1'b1; wr = 1'b1;
      if (stall) begin
        if (stall_left == 0 && $urandom_range(0, 3) == 0)
          stall_left = $urandom_range(0, 5);
        if (stall_left > 0) begin
          stall_left--;
          case ($urandom_range(0, 2))
            0: ar = 1'b0;
            1: wr = 1'b0;
            default: begin ar = 1'b0; wr = 1'b0; end
          endcase
        end
      end
      bus.act_ready = ar; bus.wgt_ready = wr;
      pend = 0;
      if (bus.act_valid === 1'b1) begin
        if (first_valid < 0) first_valid = it;
        if (ar && wr) begin
          obs_q.push_back(cur);
          last_hs = it;
        end else begin
          pend = 1;
          pend_b = cur;
        end
      end
    end
    timed_out = (done_it < 0);
    bus.start = 1'b0;
    bus.act_ready = 1'b1; bus.wgt_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b/%b exp 0/0", bus.done, bus.cfg_err); end
    checks++; if ({bus.x_rd_en, bus.w_rd_en} !== 2'b00) begin errors++;
      $display("FAIL reset_rd_en got %b%b exp 00", bus.x_rd_en, bus.w_rd_en); end
    checks++; if ({bus.act_valid, bus.wgt_valid} !== 2'b00) begin errors++;
      $display("FAIL reset_valid got %b%b exp 00", bus.act_valid, bus.wgt_valid); end
    checks++; if ({bus.x_rd_addr, bus.w_rd_addr} !== '0) begin errors++;
      $display("FAIL reset_addr got %h/%h exp 0/0", bus.x_rd_addr, bus.w_rd_addr); end
    checks++; if (get_beat() !== beat_t'(0)) begin errors++;
      $display("FAIL reset_beat got %h exp 0", get_beat()); end
  endtask

  task automatic test_basic();
    fill_mem();
    build_model(1, 16, 16, 2, 2);
    run_job(1, 16, 16, 2, 2, 0, 0);
    checks++; if (timed_out) begin errors++;
      $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (obs_q.size() != 1) begin errors++;
      $display("FAIL basic_count got %0d exp 1", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin errors++;
      $display("FAIL basic_beat got %h exp %h", obs_q[0], exp_q[0]); end
    checks++; if (obs_x.size() != 1 || obs_w.size() != 1 ||
                  obs_x[0] != 0 || obs_w[0] != 0) begin errors++;
      $display("FAIL basic_reads got %0d/%0d reads exp 1/1 at addr 0",
               obs_x.size(), obs_w.size()); end
    checks++; if (first_valid != 3) begin errors++;
      $display("FAIL basic_latency got %0d exp 3", first_valid); end
    checks++; if (done_it != last_hs + 1 || done_cnt != 1) begin errors++;
      $display("FAIL basic_done got it %0d cnt %0d exp it %0d cnt 1",
               done_it, done_cnt, last_hs + 1); end
    checks++; if (busy1 !== 1'b1 || busy_done !== 1'b0 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_busy got %b/%b err %0d exp 1/0 err 0",
               busy1, busy_done, err_cnt); end
  endtask

  task automatic test_slice_order();
    fill_mem();
    build_model(1, 16, 16, 4, 8);
    run_job(1, 16, 16, 4, 8, 0, 0);
    checks++; if (obs_q.size() != 8) begin errors++;
      $display("FAIL slice_count got %0d exp 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin errors++;
        $display("FAIL slice_beat%0d got missing exp %0d/%0d",
                 i, exp_q[i].as, exp_q[i].ws); end
      else if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL slice_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_k_pad();
    fill_mem();
    build_model(1, 20, 16, 2, 2);
    run_job(1, 20, 16, 2, 2, 0, 0);
    checks++; if (obs_q.size() != 2) begin errors++;
      $display("FAIL kpad_count got %0d exp 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin errors++;
        $display("FAIL kpad_beat%0d got missing exp k %0d", i, exp_q[i].koff); end
      else if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL kpad_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q.size() > 1 &&
        (obs_q[1].koff !== 16'd16 || obs_q[1].act[9*3 +: 3] !== 3'b100)) begin
      errors++;
      $display("FAIL kpad_lane9 got k %0d lane %b exp k 16 lane 100",
               obs_q[1].koff, obs_q[1].act[9*3 +: 3]); end
  endtask

  task automatic test_n_pad();
    fill_mem();
    build_model(2, 16, 20, 2, 2);
    run_job(2, 16, 20, 2, 2, 0, 0);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL npad_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin errors++;
        $display("FAIL npad_beat%0d got missing", i); end
      else if (obs_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL npad_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_x.size(); i++) begin
      checks++;
      if (i >= obs_x.size() || i >= obs_w.size()) begin errors++;
        $display("FAIL npad_read%0d got missing exp %0d/%0d", i, exp_x[i], exp_w[i]); end
      else if (obs_x[i] != exp_x[i] || obs_w[i] != exp_w[i]) begin errors++;
        $display("FAIL npad_read%0d got %0d/%0d exp %0d/%0d",
                 i, obs_x[i], obs_w[i], exp_x[i], exp_w[i]); end
    end
  endtask

  task automatic test_backpressure(input int M, input int K, input int N,
                                   input int ab, input int wb, input int poke);
    int bad;
    fill_mem();
    build_model(M, K, N, ab, wb);
    run_job(M, K, N, ab, wb, 1, poke);
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    checks++; if (timed_out) begin errors++;
      $display("FAIL bp_timeout M%0d K%0d N%0d got no done exp done", M, K, N); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++;
      $display("FAIL bp_count M%0d K%0d N%0d %0d/%0d got %0d exp %0d",
               M, K, N, ab, wb, obs_q.size(), exp_q.size()); end
    checks++; if (bad >= 0) begin errors++;
      $display("FAIL bp_beat%0d got %h exp %h", bad, obs_q[bad], exp_q[bad]); end
    checks++; if (stab_err != 0 || vmis != 0) begin errors++;
      $display("FAIL bp_stable got %0d unstable %0d split exp 0/0", stab_err, vmis); end
    checks++; if (obs_x.size() != exp_x.size() || done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL bp_misc got reads %0d done %0d err %0d exp %0d/1/0",
               obs_x.size(), done_cnt, err_cnt, exp_x.size()); end
  endtask

  task automatic test_cfg_err(input int M, input int K, input int N,
                              input int ab, input int wb);
    run_job(M, K, N, ab, wb, 0, 0);
    checks++; if (done_it != 1 || err_cnt != 1 || done_cnt != 1) begin errors++;
      $display("FAIL err_pulse got done@%0d cnt %0d err %0d exp done@1 cnt 1 err 1",
               done_it, done_cnt, err_cnt); end
    checks++; if (obs_x.size() + obs_w.size() + obs_q.size() != 0) begin errors++;
      $display("FAIL err_activity got %0d reads %0d beats exp 0/0",
               obs_x.size() + obs_w.size(), obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n, dn;
    fill_mem();
    @(negedge clk);
    bus.cfg_m = 16'd1; bus.cfg_k = 16'd48; bus.cfg_n = 16'd16;
    bus.cfg_act_bits = 8'd16; bus.cfg_wgt_bits = 8'd16;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.act_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.act_valid !== 1'b1) begin errors++;
      $display("FAIL rstmid_send got valid %b exp 1", bus.act_valid); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.act_valid, bus.wgt_valid,
                   bus.x_rd_en, bus.w_rd_en} !== 6'b0) begin errors++;
      $display("FAIL rstmid_ctrl got %b%b%b%b%b%b exp 000000", bus.busy,
               bus.done, bus.act_valid, bus.wgt_valid, bus.x_rd_en, bus.w_rd_en); end
    checks++; if (get_beat() !== beat_t'(0)) begin errors++;
      $display("FAIL rstmid_beat got %h exp 0", get_beat()); end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    checks++; if (dn != 0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_nodone got done %0d busy %b exp 0/0", dn, bus.busy); end
  endtask

  initial begin
    int bt[4];
    bt = '{2, 4, 8, 16};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_m = '0; bus.cfg_k = '0; bus.cfg_n = '0;
    bus.cfg_act_bits = '0; bus.cfg_wgt_bits = '0;
    bus.act_ready = 1'b1; bus.wgt_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_slice_order();
    test_k_pad();
    test_n_pad();
    test_backpressure(2, 40, 24, 4, 4, 0);
    for (int r = 0; r < 4; r++)
      test_backpressure($urandom_range(1, 2), $urandom_range(1, 48),
                        $urandom_range(1, 40), bt[$urandom_range(0, 3)],
                        bt[$urandom_range(0, 3)], 2);
    test_cfg_err(1, 16, 16, 6, 2);
    test_cfg_err(1, 0, 16, 2, 2);
    test_reset_mid();
    test_basic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
